// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared FSM state type, funct3 field positions and access-size encodings
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC0 = 2'd1,
    S_ACC1 = 2'd2,
    S_RESP = 2'd3
  } lsu_state_t;

  localparam int F3_SZ_LO   = 0;
  localparam int F3_SZ_HI   = 1;
  localparam int F3_UNS_BIT = 2;

  localparam logic [1:0] LSU_SZ_B = 2'd0;
  localparam logic [1:0] LSU_SZ_H = 2'd1;
  localparam logic [1:0] LSU_SZ_W = 2'd2;
  localparam logic [1:0] LSU_SZ_D = 2'd3;

  function automatic logic [3:0] lsu_nbytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/lsu_lane_shift.sv
// rtl/lsu_lane_shift.sv - combinational store lane shift/mask and load extract/extend
// Works on a two-beat window so a misaligned access spanning two words shifts in one step.
module lsu_lane_shift
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]           i_wdata,
  input  logic [$clog2(XLEN/8)-1:0] i_off,
  input  logic [1:0]                i_size,
  input  logic                      i_unsigned,
  input  logic [2*XLEN-1:0]         i_buf,
  output logic [2*XLEN-1:0]         o_wdata,
  output logic [XLEN/4-1:0]         o_mask,
  output logic [XLEN-1:0]           o_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  logic [OFF_W+2:0] w_sh_amt;
  logic [3:0]       w_nb;
  logic [2*NB-1:0]  w_mask_base;
  logic [XLEN-1:0]  w_sh;
  logic             w_sign;

  assign w_sh_amt = {i_off, 3'b000};
  assign w_nb     = lsu_nbytes(i_size);
  assign o_wdata  = {{XLEN{1'b0}}, i_wdata} << w_sh_amt;
  assign o_mask   = w_mask_base << i_off;
  assign w_sh     = XLEN'(i_buf >> w_sh_amt);

  always_comb begin
    w_mask_base = '0;
    for (int i = 0; i < NB; i++) w_mask_base[i] = (i < int'(w_nb));
  end

  always_comb begin
    w_sign = 1'b0;
    case (i_size)
      LSU_SZ_B: w_sign = w_sh[7];
      LSU_SZ_H: w_sign = w_sh[15];
      LSU_SZ_W: w_sign = w_sh[31];
      default:  w_sign = w_sh[XLEN-1];
    endcase
    if (i_unsigned) w_sign = 1'b0;
    o_rdata = '0;
    for (int i = 0; i < XLEN; i++) o_rdata[i] = (i < 8 * int'(w_nb)) ? w_sh[i] : w_sign;
  end

endmodule

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load/store alignment FSM between datapath and word-addressed memory
// Define LSU_MISALIGNED_EN to split misaligned accesses into two aligned beats.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_byte_enable,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_resp
);

  localparam int         NB     = XLEN / 8;
  localparam int         OFF_W  = $clog2(NB);
  localparam logic [1:0] SZ_MAX = 2'(OFF_W);

  lsu_state_t        r_state, w_state_next;
  logic              r_store, r_err;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata, r_buf_lo;
`ifdef LSU_MISALIGNED_EN
  logic [XLEN-1:0]   r_buf_hi;
  logic              w_cross;
`else
  logic              w_misal;
  logic [OFF_W-1:0]  w_align_mask;
`endif
  logic              w_hs, w_req_err, w_hi;
  logic [ADDR_W-1:0] w_base, w_beat_addr;
  logic [2*XLEN-1:0] w_buf, w_wdata2;
  logic [2*NB-1:0]   w_mask2;
  logic [XLEN-1:0]   w_rdata;

  // Ready is also gated by rst so nothing is accepted while reset is held.
  assign req_ready   = (r_state == S_IDLE) && rst;
  assign w_hs        = req_valid && req_ready;
  assign w_base      = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_hi        = (r_state == S_ACC1);
  assign w_beat_addr = w_hi ? w_base + ADDR_W'(NB) : w_base;

`ifdef LSU_MISALIGNED_EN
  assign w_buf     = {r_buf_hi, r_buf_lo};
  assign w_cross   = (32'(r_addr[OFF_W-1:0]) + 32'(lsu_nbytes(r_funct3[F3_SZ_HI:F3_SZ_LO]))) > 32'(NB);
  assign w_req_err = (req_funct3[F3_SZ_HI:F3_SZ_LO] > SZ_MAX) || (req_funct3[F3_UNS_BIT] && req_store);
`else
  assign w_buf = {{XLEN{1'b0}}, r_buf_lo};
  always_comb begin
    w_align_mask = '0;
    for (int i = 0; i < OFF_W; i++) w_align_mask[i] = (i < int'(req_funct3[F3_SZ_HI:F3_SZ_LO]));
  end
  assign w_misal   = |(req_addr[OFF_W-1:0] & w_align_mask);
  assign w_req_err = (req_funct3[F3_SZ_HI:F3_SZ_LO] > SZ_MAX) || (req_funct3[F3_UNS_BIT] && req_store) || w_misal;
`endif

  lsu_lane_shift #(.XLEN(XLEN)) u_lane_shift (
    .i_wdata    (r_wdata),
    .i_off      (r_addr[OFF_W-1:0]),
    .i_size     (r_funct3[F3_SZ_HI:F3_SZ_LO]),
    .i_unsigned (r_funct3[F3_UNS_BIT]),
    .i_buf      (w_buf),
    .o_wdata    (w_wdata2),
    .o_mask     (w_mask2),
    .o_rdata    (w_rdata)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_hs) w_state_next = w_req_err ? S_RESP : S_ACC0;
`ifdef LSU_MISALIGNED_EN
      S_ACC0: if (mem_resp) w_state_next = w_cross ? S_ACC1 : S_RESP;
      S_ACC1: if (mem_resp) w_state_next = S_RESP;
`else
      S_ACC0: if (mem_resp) w_state_next = S_RESP;
`endif
      S_RESP: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    mem_address     = '0;
    mem_wdata       = '0;
    mem_byte_enable = '0;
    resp_valid      = 1'b0;
    resp_err        = 1'b0;
    resp_rdata      = '0;
    case (r_state)
      S_ACC0, S_ACC1: begin
        mem_read        = !r_store;
        mem_write       = r_store;
        mem_address     = w_beat_addr;
        mem_wdata       = w_hi ? w_wdata2[2*XLEN-1:XLEN] : w_wdata2[XLEN-1:0];
        mem_byte_enable = !r_store ? '1 : (w_hi ? w_mask2[2*NB-1:NB] : w_mask2[NB-1:0]);
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        resp_rdata = (r_err || r_store) ? '0 : w_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_store  <= 1'b0;
      r_err    <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_buf_lo <= '0;
`ifdef LSU_MISALIGNED_EN
      r_buf_hi <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      if (w_hs) begin
        r_store  <= req_store;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_err    <= w_req_err;
      end
      if (r_state == S_ACC0 && mem_resp) r_buf_lo <= mem_rdata;
`ifdef LSU_MISALIGNED_EN
      if (r_state == S_ACC1 && mem_resp) r_buf_hi <= mem_rdata;
`endif
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// tb/tb_lsu_align.sv - directed scoreboard bench for lsu_align (XLEN=32)
// Expectations follow LSU_MISALIGNED_EN when it is defined for the build.
module tb_lsu_align;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid, resp_err;
  logic [XLEN-1:0]   resp_rdata;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_byte_enable;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_resp;

  always #5 clk = ~clk;

  lsu_align #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Handshake one request; afterwards req_* carry junk with req_valid high while busy.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd);
    exp_t e;
    e.err = exp_err;
    e.rdata = exp_rd;
    sb.push_back(e);
    req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(negedge clk);
    chk("issue.ready", req_ready, 1);
    chk("issue.idle_valid", resp_valid, 0);
    step;
    req_store  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // Memory answers one cycle after it first sees the strobe.
  task automatic beat(input string tag, input logic st, input logic [31:0] ea,
                      input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] rd);
    @(negedge clk);
    chk({tag, ".read"}, mem_read, !st);
    chk({tag, ".write"}, mem_write, st);
    chk({tag, ".addr"}, mem_address, ea);
    chk({tag, ".be"}, mem_byte_enable, ebe);
    if (st) chk({tag, ".wdata"}, mem_wdata, ewd);
    step;
    mem_resp = 1'b1;
    mem_rdata = rd;
    @(negedge clk);
    chk({tag, ".held"}, st ? mem_write : mem_read, 1);
    chk({tag, ".early_valid"}, resp_valid, 0);
    step;
    mem_resp = 1'b0;
    mem_rdata = $urandom;
  endtask

  task automatic resp(input string tag);
    exp_t e;
    req_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".valid"}, resp_valid, 1);
    chk({tag, ".no_read"}, mem_read, 0);
    chk({tag, ".no_write"}, mem_write, 0);
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".err"}, resp_err, e.err);
      chk({tag, ".rdata"}, resp_rdata, e.rdata);
    end
    step;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; mem_rdata = '0; mem_resp = 1'b0;
    step;
    step;
    @(negedge clk);
    chk("rst.ready", req_ready, 0);
    chk("rst.resp_valid", resp_valid, 0);
    chk("rst.resp_err", resp_err, 0);
    chk("rst.resp_rdata", resp_rdata, 0);
    chk("rst.mem_read", mem_read, 0);
    chk("rst.mem_write", mem_write, 0);
    chk("rst.mem_address", mem_address, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    chk("rst.mem_be", mem_byte_enable, 0);
    step;
    rst = 1'b1;
    @(negedge clk);
    chk("rst.ready_rise", req_ready, 1);
    step;

    issue(0, 3'b010, 32'h4000_0004, 0, 0, 32'hDEAD_BEEF);
    beat("lw", 0, 32'h4000_0004, 4'hF, 0, 32'hDEAD_BEEF);
    resp("lw");

    issue(0, 3'b000, 32'h4000_0003, 0, 0, 32'hFFFF_FF80);
    beat("lb", 0, 32'h4000_0000, 4'hF, 0, 32'h8011_2233);
    resp("lb");

    issue(0, 3'b100, 32'h4000_0003, 0, 0, 32'h0000_0080);
    beat("lbu", 0, 32'h4000_0000, 4'hF, 0, 32'h8011_2233);
    resp("lbu");

    issue(0, 3'b001, 32'h4000_0002, 0, 0, 32'hFFFF_8001);
    beat("lh", 0, 32'h4000_0000, 4'hF, 0, 32'h8001_1234);
    resp("lh");

    issue(0, 3'b101, 32'h4000_0002, 0, 0, 32'h0000_8001);
    beat("lhu", 0, 32'h4000_0000, 4'hF, 0, 32'h8001_1234);
    resp("lhu");

    issue(1, 3'b001, 32'h4000_0002, 32'h0000_ABCD, 0, 0);
    beat("sh", 1, 32'h4000_0000, 4'b1100, 32'hABCD_0000, 32'h1111_1111);
    resp("sh");

    issue(1, 3'b000, 32'h4000_0001, 32'h0000_00A5, 0, 0);
    beat("sb", 1, 32'h4000_0000, 4'b0010, 32'h0000_A500, 32'h2222_2222);
    resp("sb");

    issue(1, 3'b010, 32'h4000_0008, 32'h1234_5678, 0, 0);
    beat("sw", 1, 32'h4000_0008, 4'hF, 32'h1234_5678, 32'h3333_3333);
    resp("sw");

    issue(0, 3'b011, 32'h4000_0000, 0, 1, 0);
    resp("ld_err");

    issue(1, 3'b110, 32'h4000_0000, 32'h5555_5555, 1, 0);
    resp("su_err");

`ifdef LSU_MISALIGNED_EN
    issue(0, 3'b010, 32'h4000_0003, 0, 0, 32'h7766_5544);
    beat("mlw0", 0, 32'h4000_0000, 4'hF, 0, 32'h4433_2211);
    beat("mlw1", 0, 32'h4000_0004, 4'hF, 0, 32'h8877_6655);
    resp("mlw");

    issue(1, 3'b010, 32'h4000_0003, 32'hAABB_CCDD, 0, 0);
    beat("msw0", 1, 32'h4000_0000, 4'b1000, 32'hDD00_0000, 0);
    beat("msw1", 1, 32'h4000_0004, 4'b0111, 32'h00AA_BBCC, 0);
    resp("msw");

    issue(0, 3'b001, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_CDAB);
    beat("wrap0", 0, 32'hFFFF_FFFC, 4'hF, 0, 32'hAB00_0000);
    beat("wrap1", 0, 32'h0000_0000, 4'hF, 0, 32'h0000_00CD);
    resp("wrap");

    issue(0, 3'b001, 32'h4000_0001, 0, 0, 32'hFFFF_BEEF);
    beat("mlh", 0, 32'h4000_0000, 4'hF, 0, 32'h00BE_EF00);
    resp("mlh");
`else
    issue(0, 3'b010, 32'h4000_0003, 0, 1, 0);
    resp("mlw_err");

    issue(1, 3'b010, 32'h4000_0003, 32'hAABB_CCDD, 1, 0);
    resp("msw_err");

    issue(0, 3'b001, 32'hFFFF_FFFF, 0, 1, 0);
    resp("wrap_err");

    issue(0, 3'b001, 32'h4000_0001, 0, 1, 0);
    resp("mlh_err");
`endif

    // Reset during ACC0 with the memory never answering.
    issue(0, 3'b010, 32'h4000_0010, 0, 0, 0);
    void'(sb.pop_back());
    @(negedge clk);
    chk("abort.strobe", mem_read, 1);
    rst = 1'b0;
    step;
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort.read_drop", mem_read, 0);
    chk("abort.no_valid", resp_valid, 0);
    chk("abort.ready_low", req_ready, 0);
    step;
    rst = 1'b1;
    @(negedge clk);
    chk("abort.ready_back", req_ready, 1);
    chk("abort.no_valid2", resp_valid, 0);
    mem_resp = 1'b1;
    step;
    mem_resp = 1'b0;
    @(negedge clk);
    chk("idle.ignore_resp", resp_valid, 0);
    chk("idle.no_read", mem_read, 0);
    chk("idle.ready", req_ready, 1);
    step;

    issue(0, 3'b010, 32'h4000_0020, 0, 0, 32'hCAFE_F00D);
    beat("post", 0, 32'h4000_0020, 4'hF, 0, 32'hCAFE_F00D);
    resp("post");
    chk("sb.drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
